stream_reader_scheduler: RTL and testbench
==========================================

STREAM_READER_SCHEDULER -- requirements
Module: stream_reader_scheduler

Interface
REQ-001 Parameter NUMBER_OF_ACTIVATION_LINE_BUFFERS, default 4: number of line buffers sequenced; power of two, at least 2.
REQ-002 Parameter ACTIVATION_LINE_BUFFER_DEPTH, default 1024: words per line buffer; AW = $clog2(ACTIVATION_LINE_BUFFER_DEPTH).
REQ-003 Parameter ROW_COUNT_WIDTH, default 16: width of the row and beat counters.
REQ-004 clk, input, 1: clock; all logic rising-edge.
REQ-005 resetn, input, 1: reset, synchronous, active-low.
REQ-006 i_local_resetn, input, 1: layer-level soft reset, synchronous, active-low.
REQ-007 i_start, input, 1: single-cycle pulse; launches a job.
REQ-008 i_num_rows, input, ROW_COUNT_WIDTH: rows in the job; sampled at accepted i_start.
REQ-009 i_row_length, input, ROW_COUNT_WIDTH: beats per row; sampled at accepted i_start.
REQ-010 i_base_address, input, AW: start address of the first row in each buffer; sampled at accepted i_start.
REQ-011 o_stream_read_enable, output, NUMBER_OF_ACTIVATION_LINE_BUFFERS: one-hot enable of the selected buffer's stream reader.
REQ-012 o_start_stream_readers, output, 1: single-cycle pulse that loads the start address into the selected reader.
REQ-013 o_stream_read_start_address, output, AW: start address for the current row.
REQ-014 i_beat_valid / i_beat_ready, input, 1 each: streamed-data handshake observed on the selected reader; a beat is counted when both are 1.
REQ-015 o_busy, output, 1: high from the accepted i_start until the DONE state is left.
REQ-016 o_done, output, 1: single-cycle pulse at job completion.

Function
REQ-017 FSM states: IDLE, LAUNCH, STREAM, NEXT, DONE.
REQ-018 IDLE: on i_start=1 with i_num_rows!=0 and i_row_length!=0, latch the inputs, clear the row counter, and go to LAUNCH; any other i_start is ignored.
REQ-019 In IDLE, i_start with zero rows or zero length goes directly to DONE, and o_done pulses on the next cycle.
REQ-020 LAUNCH, one cycle: assert o_start_stream_readers and the one-hot bit for buffer row mod NUMBER_OF_ACTIVATION_LINE_BUFFERS; clear the beat counter; go to STREAM.
REQ-021 Start address = (base + (row / NUMBER_OF_ACTIVATION_LINE_BUFFERS) * row_length) mod ACTIVATION_LINE_BUFFER_DEPTH; the value wraps and is truncated to AW bits.
REQ-022 The start address is registered and stable from LAUNCH through the end of STREAM.
REQ-023 STREAM: hold the enable bit; increment the beat counter on each accepted beat; on the beat that reaches row_length, go to NEXT in the following cycle.
REQ-024 NEXT, one cycle: deassert all enables; increment the row counter; if it equals num_rows, go to DONE, else go to LAUNCH.
REQ-025 DONE: pulse o_done for one cycle, then go to IDLE; o_busy falls with the return to IDLE.
REQ-026 An i_start while busy is ignored; it is not queued.
REQ-027 Beats outside STREAM are not counted.
REQ-028 At most one enable bit is high in any cycle.
REQ-029 Start-to-first-LAUNCH latency is 1 cycle; per-row overhead is 2 cycles (NEXT and LAUNCH).

Reset
REQ-030 resetn=0 or i_local_resetn=0 (resetn has priority) puts the FSM in IDLE and clears all counters.
REQ-031 Reset values: o_stream_read_enable=0, o_start_stream_readers=0, o_stream_read_start_address=0, o_busy=0, o_done=0.
REQ-032 A reset in any state aborts the job within one cycle, with no o_done pulse.

Configuration
REQ-033 With macro STREAM_SCHEDULER_PERF_COUNTER_EN defined, add output o_stall_cycles (32 bits), which counts STREAM cycles in which i_beat_valid=1 and i_beat_ready=0.
REQ-034 o_stall_cycles clears on an accepted i_start or any reset, and saturates at all-ones.
REQ-035 With STREAM_SCHEDULER_PERF_COUNTER_EN undefined, the port and counter are absent, and all other behaviour is identical.

Verification
REQ-036 Stimulus: base=0, rows=4, len=8, always ready. Response: enables 0001, 0010, 0100, 1000; each start address 0; 32 beats; o_done once; total 41 cycles.
REQ-037 Stimulus: rows=6, len=100, base=1000, depth 1024. Response: rows 4 and 5 use buffers 0 and 1 with start address 76 (the address wraps).
REQ-038 Stimulus: i_start with rows=0. Response: no enable or start pulse; o_done pulses exactly 2 cycles after i_start.
REQ-039 Stimulus: i_local_resetn=0 mid-STREAM on row 2. Response: all outputs 0 next cycle; no o_done; a new i_start runs from row 0.
REQ-040 Stimulus: second i_start during a job, with i_beat_ready toggling 50%. Response: second start ignored; the beat count per row is exactly len.
REQ-041 Stimulus: STREAM_SCHEDULER_PERF_COUNTER_EN defined, 5 valid-not-ready cycles in STREAM. Response: o_stall_cycles=5.

Source files
------------

// File: rtl/stream_reader_scheduler.sv
// Sequences row-by-row reads across the activation line-buffer stream readers.
// Defining STREAM_SCHEDULER_PERF_COUNTER_EN adds the o_stall_cycles counter.
module stream_reader_scheduler #(
    parameter int unsigned NUMBER_OF_ACTIVATION_LINE_BUFFERS = 4,
    parameter int unsigned ACTIVATION_LINE_BUFFER_DEPTH      = 1024,
    parameter int unsigned ROW_COUNT_WIDTH                   = 16,
    localparam int unsigned AW = $clog2(ACTIVATION_LINE_BUFFER_DEPTH),
    localparam int unsigned NB = NUMBER_OF_ACTIVATION_LINE_BUFFERS
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       i_local_resetn,
    input  logic                       i_start,
    input  logic [ROW_COUNT_WIDTH-1:0] i_num_rows,
    input  logic [ROW_COUNT_WIDTH-1:0] i_row_length,
    input  logic [AW-1:0]              i_base_address,
    output logic [NB-1:0]              o_stream_read_enable,
    output logic                       o_start_stream_readers,
    output logic [AW-1:0]              o_stream_read_start_address,
    input  logic                       i_beat_valid,
    input  logic                       i_beat_ready,
    output logic                       o_busy,
    output logic                       o_done
`ifdef STREAM_SCHEDULER_PERF_COUNTER_EN
    ,
    output logic [31:0]                o_stall_cycles
`endif
);

    localparam int unsigned SW = $clog2(NB);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StStream,
        StNext,
        StDone
    } state_t;

    state_t                     r_state;
    logic [ROW_COUNT_WIDTH-1:0] r_num_rows;
    logic [ROW_COUNT_WIDTH-1:0] r_row_length;
    logic [ROW_COUNT_WIDTH-1:0] r_row;
    logic [ROW_COUNT_WIDTH-1:0] r_beat;
    logic [AW-1:0]              r_len_mod;
    logic [AW-1:0]              r_addr;
    logic [NB-1:0]              r_enable;
    logic                       r_start_pulse;
    logic                       r_busy;
    logic                       r_done;

    logic                       w_reset;
    logic                       w_start_ok;
    logic                       w_beat_accept;
    logic [ROW_COUNT_WIDTH-1:0] w_row_next;
    logic [ROW_COUNT_WIDTH-1:0] w_beat_next;
    logic [NB-1:0]              w_sel_next;
    logic                       w_group_wrap;
    logic [AW:0]                w_addr_sum;
    logic [AW-1:0]              w_addr_next;

    assign w_reset       = !resetn || !i_local_resetn;
    assign w_start_ok    = (i_num_rows != '0) && (i_row_length != '0);
    assign w_beat_accept = i_beat_valid && i_beat_ready;
    assign w_row_next    = r_row + ROW_COUNT_WIDTH'(1);
    assign w_beat_next   = r_beat + ROW_COUNT_WIDTH'(1);
    assign w_sel_next    = NB'(1) << w_row_next[SW-1:0];

    // A new buffer group starts every NB rows; the address advances by one row length then.
    assign w_group_wrap  = (w_row_next[SW-1:0] == '0);
    assign w_addr_sum    = {1'b0, r_addr} + {1'b0, r_len_mod};
    assign w_addr_next   = (w_addr_sum >= (AW+1)'(ACTIVATION_LINE_BUFFER_DEPTH)) ?
                           AW'(w_addr_sum - (AW+1)'(ACTIVATION_LINE_BUFFER_DEPTH)) :
                           w_addr_sum[AW-1:0];

    always_ff @(posedge clk) begin
        if (w_reset) begin
            r_state       <= StIdle;
            r_num_rows    <= '0;
            r_row_length  <= '0;
            r_row         <= '0;
            r_beat        <= '0;
            r_len_mod     <= '0;
            r_addr        <= '0;
            r_enable      <= '0;
            r_start_pulse <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_start_pulse <= 1'b0;
            r_done        <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start && w_start_ok) begin
                        r_num_rows    <= i_num_rows;
                        r_row_length  <= i_row_length;
                        r_len_mod     <= AW'(32'(i_row_length) %
                                             32'(ACTIVATION_LINE_BUFFER_DEPTH));
                        r_addr        <= i_base_address;
                        r_row         <= '0;
                        r_beat        <= '0;
                        r_enable      <= NB'(1);
                        r_start_pulse <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= StLaunch;
                    end else if (i_start) begin
                        r_busy  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StLaunch: begin
                    r_beat  <= '0;
                    r_state <= StStream;
                end
                StStream: begin
                    if (w_beat_accept) begin
                        r_beat <= w_beat_next;
                        if (w_beat_next == r_row_length) begin
                            r_enable <= '0;
                            r_state  <= StNext;
                        end
                    end
                end
                StNext: begin
                    r_row <= w_row_next;
                    if (w_row_next == r_num_rows) begin
                        r_state <= StDone;
                    end else begin
                        r_enable      <= w_sel_next;
                        r_start_pulse <= 1'b1;
                        if (w_group_wrap) begin
                            r_addr <= w_addr_next;
                        end
                        r_state <= StLaunch;
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= StIdle;
                end
                default: begin
                    r_enable <= '0;
                    r_busy   <= 1'b0;
                    r_state  <= StIdle;
                end
            endcase
        end
    end

    assign o_stream_read_enable        = r_enable;
    assign o_start_stream_readers      = r_start_pulse;
    assign o_stream_read_start_address = r_addr;
    assign o_busy                      = r_busy;
    assign o_done                      = r_done;

`ifdef STREAM_SCHEDULER_PERF_COUNTER_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (w_reset) begin
            r_stall_cycles <= '0;
        end else if (r_state == StIdle && i_start) begin
            r_stall_cycles <= '0;
        end else if (r_state == StStream && i_beat_valid && !i_beat_ready &&
                     r_stall_cycles != '1) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_stream_reader_scheduler.sv
// Self-checking bench for stream_reader_scheduler: vector table, random jobs, corner sequences.
module tb_stream_reader_scheduler;

    localparam int N     = 4;
    localparam int DEPTH = 1024;
    localparam int RCW   = 16;
    localparam int AW    = 10;

    logic           clk = 1'b0;
    logic           resetn;
    logic           i_local_resetn;
    logic           i_start;
    logic [RCW-1:0] i_num_rows;
    logic [RCW-1:0] i_row_length;
    logic [AW-1:0]  i_base_address;
    logic [N-1:0]   o_stream_read_enable;
    logic           o_start_stream_readers;
    logic [AW-1:0]  o_stream_read_start_address;
    logic           i_beat_valid;
    logic           i_beat_ready;
    logic           o_busy;
    logic           o_done;
`ifdef STREAM_SCHEDULER_PERF_COUNTER_EN
    logic [31:0]    o_stall_cycles;
`endif

    always #5 clk = ~clk;

    stream_reader_scheduler #(
        .NUMBER_OF_ACTIVATION_LINE_BUFFERS(N),
        .ACTIVATION_LINE_BUFFER_DEPTH(DEPTH),
        .ROW_COUNT_WIDTH(RCW)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .i_local_resetn(i_local_resetn),
        .i_start(i_start),
        .i_num_rows(i_num_rows),
        .i_row_length(i_row_length),
        .i_base_address(i_base_address),
        .o_stream_read_enable(o_stream_read_enable),
        .o_start_stream_readers(o_start_stream_readers),
        .o_stream_read_start_address(o_stream_read_start_address),
        .i_beat_valid(i_beat_valid),
        .i_beat_ready(i_beat_ready),
        .o_busy(o_busy),
        .o_done(o_done)
`ifdef STREAM_SCHEDULER_PERF_COUNTER_EN
        ,
        .o_stall_cycles(o_stall_cycles)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: row r reads buffer r mod N at base + (r / N) * len, wrapped to the depth.
    function automatic int exp_addr(input int base, input int r, input int len);
        return (base + (r / N) * len) % DEPTH;
    endfunction

    task automatic drive_hs(input int vp, input int rp);
        i_beat_valid = ($urandom_range(0, 99) < vp);
        i_beat_ready = ($urandom_range(0, 99) < rp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " enable"}, int'(o_stream_read_enable), 0);
        check({tag, " start"}, int'(o_start_stream_readers), 0);
        check({tag, " addr"}, int'(o_stream_read_start_address), 0);
        check({tag, " busy"}, int'(o_busy), 0);
        check({tag, " done"}, int'(o_done), 0);
    endtask

    // Runs one job and checks it at transaction level against the reference rules.
    task automatic run_job(input string tag, input int rows, input int len, input int base,
                           input int vp, input int rp, input bit second,
                           output int n_launch, output int last_addr, output int busy_cycles);
        int en_q[$];
        int addr_q[$];
        int beats_q[$];
        int last_beat_t = -100;
        int drop_t      = -100;
        int done_t      = -1;
        int done_cnt    = 0;
        int stall       = 0;
        int prot_err    = 0;
        int t;
        logic [N-1:0] prev_en = '0;
        busy_cycles = 0;
        @(negedge clk);
        i_num_rows     = RCW'(rows);
        i_row_length   = RCW'(len);
        i_base_address = AW'(base);
        i_start        = 1'b1;
        drive_hs(vp, rp);
        for (t = 1; t < 20000; t++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_busy) busy_cycles++;
            if (!$onehot0(o_stream_read_enable)) prot_err++;
            if (o_start_stream_readers) begin
                if (o_stream_read_enable == '0) prot_err++;
                if (en_q.size() == 0 ? (t != 1) : (t != drop_t + 1)) prot_err++;
                en_q.push_back(int'(o_stream_read_enable));
                addr_q.push_back(int'(o_stream_read_start_address));
                beats_q.push_back(0);
            end else if (o_stream_read_enable != '0) begin
                if (en_q.size() == 0) prot_err++;
                else if (o_stream_read_enable != prev_en ||
                         int'(o_stream_read_start_address) != addr_q[addr_q.size()-1])
                    prot_err++;
            end
            if (prev_en != '0 && o_stream_read_enable == '0) begin
                drop_t = t;
                if (t != last_beat_t + 1) prot_err++;
            end
            if (o_done) begin
                done_cnt++;
                done_t = t;
                if (o_busy) prot_err++;
            end
            if (second && t == 5) begin
                i_start        = 1'b1;
                i_num_rows     = RCW'(1);
                i_row_length   = RCW'(1);
                i_base_address = AW'(base + 7);
            end
            drive_hs(vp, rp);
            if (o_stream_read_enable != '0 && !o_start_stream_readers && beats_q.size() > 0) begin
                if (i_beat_valid && i_beat_ready) begin
                    beats_q[beats_q.size()-1]++;
                    last_beat_t = t;
                end
                if (i_beat_valid && !i_beat_ready) stall++;
            end
            prev_en = o_stream_read_enable;
            if (done_t >= 0 && t >= done_t + 4) break;
        end
        i_start = 1'b0;
        check({tag, " done count"}, done_cnt, 1);
        check({tag, " done time"}, done_t, last_beat_t + 3);
        check({tag, " launches"}, en_q.size(), rows);
        check({tag, " protocol"}, prot_err, 0);
        check({tag, " busy span"}, busy_cycles, done_t - 1);
        for (int r = 0; r < rows && r < en_q.size(); r++) begin
            check($sformatf("%s row%0d enable", tag, r), en_q[r], 1 << (r % N));
            check($sformatf("%s row%0d addr", tag, r), addr_q[r], exp_addr(base, r, len));
            check($sformatf("%s row%0d beats", tag, r), beats_q[r], len);
        end
`ifdef STREAM_SCHEDULER_PERF_COUNTER_EN
        check({tag, " stalls"}, int'(o_stall_cycles), stall);
`endif
        n_launch  = en_q.size();
        last_addr = (addr_q.size() > 0) ? addr_q[addr_q.size()-1] : -1;
    endtask

    task automatic zero_job(input string tag, input int rows, input int len);
        int done_mask = 0;
        int act       = 0;
        @(negedge clk);
        i_num_rows     = RCW'(rows);
        i_row_length   = RCW'(len);
        i_base_address = AW'(3);
        i_start        = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_done) done_mask |= (1 << t);
            if (o_stream_read_enable != '0 || o_start_stream_readers) act++;
        end
        check({tag, " done timing mask"}, done_mask, 4);
        check({tag, " activity"}, act, 0);
    endtask

    typedef struct {
        int rows;
        int len;
        int base;
        int vp;
        int rp;
        bit second;
        int exp_launch;
        int exp_last_addr;
        int exp_busy;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int nl, la, bc, cnt, guard;
        vecs[0] = '{4, 8, 0, 100, 100, 1'b0, 4, 0, 41};
        vecs[1] = '{6, 100, 1000, 100, 100, 1'b0, 6, 76, 613};
        vecs[2] = '{1, 1, 5, 100, 100, 1'b0, 1, 5, 4};
        vecs[3] = '{5, 3, 1023, 100, 50, 1'b0, 5, 2, 0};
        vecs[4] = '{9, 2, 1020, 70, 60, 1'b0, 9, 0, 0};
        vecs[5] = '{4, 10, 17, 100, 50, 1'b1, 4, 17, 0};

        resetn         = 1'b0;
        i_local_resetn = 1'b1;
        i_start        = 1'b0;
        i_num_rows     = '0;
        i_row_length   = '0;
        i_base_address = '0;
        i_beat_valid   = 1'b0;
        i_beat_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        resetn = 1'b1;
        @(negedge clk);
        check_idle_outputs("post reset");
`ifdef STREAM_SCHEDULER_PERF_COUNTER_EN
        check("reset stalls", int'(o_stall_cycles), 0);
`endif

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_job(tag, vecs[i].rows, vecs[i].len, vecs[i].base, vecs[i].vp, vecs[i].rp,
                    vecs[i].second, nl, la, bc);
            check({tag, " tbl launches"}, nl, vecs[i].exp_launch);
            check({tag, " tbl last addr"}, la, vecs[i].exp_last_addr);
            if (vecs[i].exp_busy != 0) check({tag, " tbl busy"}, bc, vecs[i].exp_busy);
        end

        zero_job("zero rows", 0, 5);
        zero_job("zero len", 3, 0);

        // Soft reset in the middle of row 2.
        @(negedge clk);
        i_num_rows     = RCW'(4);
        i_row_length   = RCW'(20);
        i_base_address = AW'(3);
        i_start        = 1'b1;
        i_beat_valid   = 1'b1;
        i_beat_ready   = 1'b1;
        cnt            = 0;
        guard          = 0;
        while (cnt < 3 && guard < 200) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_start_stream_readers) cnt++;
            guard++;
        end
        repeat (3) @(negedge clk);
        check("lrst row2 enable", int'(o_stream_read_enable), 4);
        i_local_resetn = 1'b0;
        @(negedge clk);
        i_local_resetn = 1'b1;
        check_idle_outputs("lrst");
        cnt = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (o_done || o_busy || o_stream_read_enable != '0) cnt++;
        end
        check("lrst aftermath activity", cnt, 0);
        run_job("after lrst", 3, 5, 9, 100, 100, 1'b0, nl, la, bc);

        // Global reset mid-job.
        @(negedge clk);
        i_num_rows   = RCW'(2);
        i_row_length = RCW'(30);
        i_start      = 1'b1;
        repeat (6) @(negedge clk);
        i_start = 1'b0;
        resetn  = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check_idle_outputs("grst");

`ifdef STREAM_SCHEDULER_PERF_COUNTER_EN
        // Five valid-not-ready cycles inside STREAM, one more in LAUNCH that must not count.
        @(negedge clk);
        i_num_rows     = RCW'(1);
        i_row_length   = RCW'(4);
        i_base_address = '0;
        i_start        = 1'b1;
        i_beat_valid   = 1'b1;
        i_beat_ready   = 1'b0;
        cnt            = 0;
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_done) cnt++;
            i_beat_valid = (t != 7);
            i_beat_ready = (t >= 8 && t <= 11);
        end
        check("perf stalls", int'(o_stall_cycles), 5);
        check("perf done", cnt, 1);
`endif

        for (int i = 0; i < 8; i++) begin
            run_job($sformatf("rand%0d", i), int'($urandom_range(1, 10)),
                    int'($urandom_range(1, 40)), int'($urandom_range(0, DEPTH - 1)),
                    int'($urandom_range(40, 100)), int'($urandom_range(30, 100)),
                    1'b0, nl, la, bc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
